// File: rtl/writeback_regfile.sv
// Writeback stage with result select, 31-entry register file and commit counter.
// Optional write-through bypass is enabled by defining WB_BYPASS_EN.
module writeback_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [1:0]  ResultSrcW,
   input  logic [31:0] ALUResultW,
   input  logic [31:0] ReadDataW,
   input  logic [31:0] PCPlus4W,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] ResultW,
   output logic [31:0] WbCount
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 31;

   logic [XLEN-1:0] regs_q [1:NREGS];
   logic [XLEN-1:0] wb_count_q;
   logic [XLEN-1:0] wb_count_d;
   logic            wr_en;

   // Result select; the reserved encoding writes zero.
   always_comb begin
      ResultW = '0;
      case (ResultSrcW)
         2'b00:   ResultW = ALUResultW;
         2'b01:   ResultW = ReadDataW;
         2'b10:   ResultW = PCPlus4W;
         default: ResultW = '0;
      endcase
   end

   // A write commits only outside reset and never to x0.
   always_comb begin
      wr_en      = RegWriteW && (RdW != 5'd0) && !rst;
      wb_count_d = wb_count_q;
      if (wr_en) wb_count_d = wb_count_q + XLEN'(1);
   end

   // Register array update with reset priority over writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i <= int'(NREGS); i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[RdW] <= ResultW;
      end
   end

   // Commit counter; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) wb_count_q <= '0;
      else     wb_count_q <= wb_count_d;
   end

   assign WbCount = wb_count_q;

`ifdef WB_BYPASS_EN
   // Read ports with same-cycle write-through forwarding.
   always_comb begin
      RD1D = '0;
      RD2D = '0;
      if (Rs1D != 5'd0) RD1D = (wr_en && (Rs1D == RdW)) ? ResultW : regs_q[Rs1D];
      if (Rs2D != 5'd0) RD2D = (wr_en && (Rs2D == RdW)) ? ResultW : regs_q[Rs2D];
   end
`else
   // Read ports return pre-edge contents; hazard unit covers the write gap.
   always_comb begin
      RD1D = '0;
      RD2D = '0;
      if (Rs1D != 5'd0) RD1D = regs_q[Rs1D];
      if (Rs2D != 5'd0) RD2D = regs_q[Rs2D];
   end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed cases plus randomized traffic
// against an array-based reference model. Honors WB_BYPASS_EN like the design.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  Rs1D, Rs2D;
   logic [31:0] RD1D, RD2D, ResultW, WbCount;

   int tests  = 0;
   int failed = 0;

   logic [31:0] mem [32];
   logic [31:0] cnt;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   writeback_regfile dut (
      .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
      .WbCount(WbCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_result(input logic [1:0] src, input logic [31:0] a,
                                                input logic [31:0] d, input logic [31:0] p);
      case (src)
         2'd0:    return a;
         2'd1:    return d;
         2'd2:    return p;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] addr, input logic r,
                                              input logic we, input logic [4:0] rd,
                                              input logic [31:0] res);
      if (addr == 5'd0) return 32'h0;
      if (BYPASS && we && !r && rd == addr) return res;
      return mem[addr];
   endfunction

   // One clock: drive at negedge, check combinational outputs, clock, update model.
   task automatic cycle(input logic r, input logic we, input logic [4:0] rd,
                        input logic [1:0] src, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2,
                        input string tag);
      logic [31:0] res;
      rst = r; RegWriteW = we; RdW = rd; ResultSrcW = src;
      ALUResultW = alu; ReadDataW = rdat; PCPlus4W = pc4; Rs1D = a1; Rs2D = a2;
      res = model_result(src, alu, rdat, pc4);
      #1;
      check({tag, "_result"}, ResultW, res);
      check({tag, "_rd1"}, RD1D, model_read(a1, r, we, rd, res));
      check({tag, "_rd2"}, RD2D, model_read(a2, r, we, rd, res));
      check({tag, "_cnt"}, WbCount, cnt);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         cnt = 32'h0;
      end else if (we && rd != 5'd0) begin
         mem[rd] = res;
         cnt     = cnt + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
      rst = 1'b0; RegWriteW = 1'b0; Rs1D = a1; Rs2D = a2;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      cnt = 32'h0;
      rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultSrcW = '0;
      ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; Rs1D = '0; Rs2D = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_read(5'd1, 5'd31);
      check("reset_rd1", RD1D, 32'h0);
      check("reset_rd2", RD2D, 32'h0);
      check("reset_cnt", WbCount, 32'h0);

      // Basic write then read.
      cycle(0, 1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 5'd0, "wr5");
      idle_read(5'd5, 5'd5);
      check("req027_rd1", RD1D, 32'h1234_5678);
      check("req027_rd2_same", RD2D, 32'h1234_5678);
      check("req027_cnt", WbCount, 32'd1);

      // Write to x0 is discarded and uncounted.
      cycle(0, 1, 5'd0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0, "wr0");
      idle_read(5'd0, 5'd0);
      check("req028_rd1", RD1D, 32'h0);
      check("req028_rd2", RD2D, 32'h0);
      check("req028_cnt", WbCount, 32'd1);

      // Source select including the reserved encoding.
      cycle(0, 1, 5'd6, 2'b01, 32'hFFFF_0000, 32'hA5A5_0001, 32'h0000_0999, 5'd0, 5'd0, "src1");
      cycle(0, 1, 5'd7, 2'b10, 32'hFFFF_0000, 32'hA5A5_0002, 32'h0000_0104, 5'd0, 5'd0, "src2");
      cycle(0, 1, 5'd8, 2'b11, 32'hFFFF_0000, 32'hA5A5_0003, 32'h0000_0777, 5'd0, 5'd0, "src3");
      idle_read(5'd6, 5'd7);
      check("req029_x6", RD1D, 32'hA5A5_0001);
      check("req029_x7", RD2D, 32'h0000_0104);
      idle_read(5'd8, 5'd5);
      check("req029_x8", RD1D, 32'h0);
      check("req029_cnt", WbCount, 32'd4);

      // Same-cycle read of the register being written.
      rst = 1'b0; RegWriteW = 1'b1; RdW = 5'd9; ResultSrcW = 2'b00;
      ALUResultW = 32'h0000_00FF; Rs1D = 5'd0; Rs2D = 5'd9;
      #1;
      check("req030_bypass", RD2D, BYPASS ? 32'h0000_00FF : 32'h0);
      cycle(0, 1, 5'd9, 2'b00, 32'h0000_00FF, 32'h0, 32'h0, 5'd0, 5'd9, "byp");
      idle_read(5'd9, 5'd0);
      check("req030_after", RD1D, 32'h0000_00FF);

      // Reset colliding with a write.
      cycle(0, 1, 5'd3, 2'b00, 32'h1111_1111, 32'h0, 32'h0, 5'd3, 5'd0, "x3");
      cycle(1, 1, 5'd3, 2'b00, 32'h2222_2222, 32'h0, 32'h0, 5'd3, 5'd9, "rstcol");
      idle_read(5'd3, 5'd9);
      check("req031_rd1", RD1D, 32'h0);
      check("req031_rd2", RD2D, 32'h0);
      check("req031_cnt", WbCount, 32'h0);

      // Counter wrap via backdoor preload.
      dut.wb_count_q = 32'hFFFF_FFFF;
      cnt = 32'hFFFF_FFFF;
      cycle(0, 1, 5'd12, 2'b00, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd12, 5'd0, "wrap");
      idle_read(5'd12, 5'd0);
      check("req032_cnt", WbCount, 32'h0);
      check("req032_rd", RD1D, 32'h0BAD_F00D);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic        r, we;
         logic [4:0]  rd, a1, a2;
         logic [1:0]  src;
         r   = ($urandom_range(0, 39) == 0);
         we  = ($urandom_range(0, 3) != 0);
         rd  = 5'($urandom_range(0, 31));
         src = 2'($urandom_range(0, 3));
         a1  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         a2  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         cycle(r, we, rd, src, $urandom, $urandom, $urandom, a1, a2, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port RegWriteW, input, 1 bit: writeback enable from the MEM/WB bundle.
REQ-004 SHALL have port RdW, input, 5 bits: destination register index.
REQ-005 SHALL have port ResultSrcW, input, 2 bits: result select; 00 = ALU, 01 = load data, 10 = PC+4, 11 = reserved.
REQ-006 SHALL have ports ALUResultW, ReadDataW and PCPlus4W, each input, 32 bits: candidate writeback values.
REQ-007 SHALL have ports Rs1D and Rs2D, each input, 5 bits: decode-stage read addresses.
REQ-008 SHALL have ports RD1D and RD2D, each output, 32 bits: combinational read data.
REQ-009 SHALL have port ResultW, output, 32 bits: selected writeback value, combinational, for EX-stage forwarding.
REQ-010 SHALL have port WbCount, output, 32 bits: registered count of committed register writes.

Function
REQ-011 SHALL drive ResultW as follows: 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> 32'h0000_0000.
REQ-012 SHALL hold 31 architectural 32-bit registers, x1..x31; x0 has no storage.
REQ-013 SHALL write ResultW into x[RdW] on a rising edge when RegWriteW=1, RdW!=0 and rst=0; no other register changes.
REQ-014 SHALL discard a write with RdW=0 and SHALL NOT count it.
REQ-015 SHALL return 0 on RD1D/RD2D whenever the corresponding address is 0, regardless of any write.
REQ-016 SHALL otherwise return stored register contents combinationally (zero-cycle read latency).
REQ-017 SHALL serve both read ports independently; Rs1D=Rs2D is legal and both ports return the same value.
REQ-018 SHALL increment WbCount by 1 on each rising edge that performs a write per REQ-013.
REQ-019 SHALL wrap WbCount from 32'hFFFF_FFFF to 0 without flagging.
REQ-020 SHALL treat ResultSrcW=11 with RegWriteW=1 as a legal write of 0 that is counted.

Reset
REQ-021 SHALL, on a rising edge with rst=1, clear x1..x31 and WbCount to 0.
REQ-022 SHALL give rst priority over any simultaneous write: the write is lost and not counted.
REQ-023 SHALL, when rst is asserted mid-stream, present all-zero reads from the first edge after rst was sampled high; ResultW stays combinational and unaffected.

Configuration
REQ-024 SHALL support the macro WB_BYPASS_EN, which controls write-through bypass.
REQ-025 SHALL, with WB_BYPASS_EN defined, drive RDxD = ResultW in the same cycle when Rs*D = RdW, RdW != 0, RegWriteW = 1 and rst = 0.
REQ-026 SHALL, with WB_BYPASS_EN undefined, return the pre-edge stored value; the written value becomes visible the cycle after the write, and the hazard unit covers the gap.

Verification
REQ-027 SHALL cover write/read: RegWriteW=1, RdW=5, ResultSrcW=00, ALUResultW=32'h1234_5678 for one edge; then Rs1D=5 -> RD1D=32'h1234_5678 and WbCount=1.
REQ-028 SHALL cover x0: RegWriteW=1, RdW=0, ALUResultW=32'hDEAD_BEEF; then Rs1D=0, Rs2D=0 -> RD1D=RD2D=0 and WbCount unchanged.
REQ-029 SHALL cover source select: the same edge sequence with ResultSrcW=01 (ReadDataW=32'hA5A5_0001), 10 (PCPlus4W=32'h0000_0104) and 11 into x6, x7, x8 -> reads of 32'hA5A5_0001, 32'h0000_0104 and 0.
REQ-030 SHALL cover bypass: in the same cycle, RdW=9, RegWriteW=1, ALUResultW=32'h0000_00FF, Rs2D=9 -> RD2D=32'h0000_00FF before the edge with WB_BYPASS_EN defined, and the old value (0 after reset) without it.
REQ-031 SHALL cover reset collision: x3 loaded with 32'h1111_1111; then rst=1 together with a write of 32'h2222_2222 to x3 -> after the edge RD1D(Rs1D=3)=0 and WbCount=0.
REQ-032 SHALL cover counter wrap: WbCount forced by 2^32-1 committed writes (or preloaded via a bench backdoor) plus one more write -> WbCount=0.
